// File: rtl/multicycle_sequencer_pkg.sv
// Shared constants for the multi-cycle RV32I sequencer: opcodes, ALU op classes,
// FSM state and instruction-class encodings.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_R     = 3'd1,
        CLS_I     = 3'd2,
        CLS_L     = 3'd3,
        CLS_S     = 3'd4,
        CLS_CB    = 3'd5,
        CLS_LUI   = 3'd6,
        CLS_AUIPC = 3'd7
    } iclass_t;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_L     = 7'b0000011;
    localparam logic [6:0] OPC_S     = 7'b0100011;
    localparam logic [6:0] OPC_CB    = 7'b1100011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;

    localparam logic [2:0] ALU_OP_LW_SW_type = 3'd0;
    localparam logic [2:0] ALU_OP_CB_type    = 3'd1;
    localparam logic [2:0] ALU_OP_R_type     = 3'd2;
    localparam logic [2:0] ALU_OP_I_type     = 3'd3;
    localparam logic [2:0] ALU_OP_LUI_type   = 3'd4;
    localparam logic [2:0] ALU_OP_AUIPC_type = 3'd5;

    // Returns {alu_op, alu_src} for an instruction class.
    function automatic logic [3:0] class_alu(iclass_t c);
        case (c)
            CLS_R:     return {ALU_OP_R_type,     1'b0};
            CLS_I:     return {ALU_OP_I_type,     1'b1};
            CLS_L:     return {ALU_OP_LW_SW_type, 1'b1};
            CLS_S:     return {ALU_OP_LW_SW_type, 1'b1};
            CLS_CB:    return {ALU_OP_CB_type,    1'b0};
            CLS_LUI:   return {ALU_OP_LUI_type,   1'b1};
            CLS_AUIPC: return {ALU_OP_AUIPC_type, 1'b1};
            default:   return '0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Datapath-facing bundle of the sequencer: IR opcode, branch result, memory
// handshakes and datapath control strobes.
interface multicycle_sequencer_if;
    logic [6:0] opcode;
    logic       branch_cond;
    logic       imem_req;
    logic       imem_ready;
    logic       dmem_ready;
    logic       ir_write;
    logic       pc_write;
    logic       PC_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_write_en;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;

    modport master (
        input  opcode, branch_cond, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, PC_src, alu_op, alu_src,
               reg_write_en, mem_read, mem_write, mem_to_reg
    );

    modport slave (
        output opcode, branch_cond, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, PC_src, alu_op, alu_src,
               reg_write_en, mem_read, mem_write, mem_to_reg
    );
endinterface

// File: rtl/multicycle_sequencer_class_decode.sv
// Combinational opcode classifier; JAL/JALR and unknown opcodes are illegal.
module seq_class_decode
    import multicycle_sequencer_pkg::*;
(
    input  logic [6:0] opcode,
    output iclass_t    iclass,
    output logic       legal
);

    always_comb begin
        iclass = CLS_NONE;
        case (opcode)
            OPC_R:     iclass = CLS_R;
            OPC_I:     iclass = CLS_I;
            OPC_L:     iclass = CLS_L;
            OPC_S:     iclass = CLS_S;
            OPC_CB:    iclass = CLS_CB;
            OPC_LUI:   iclass = CLS_LUI;
            OPC_AUIPC: iclass = CLS_AUIPC;
            default:   iclass = CLS_NONE;
        endcase
    end

    assign legal = (iclass != CLS_NONE);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXEC/MEM/WB + TRAP).
// Define MEM_TIMEOUT_EN to bound memory waits to TIMEOUT_CYCLES and trap on expiry.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned INSTRET_W      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    halt,
    multicycle_sequencer_if.master  bus,
    output logic                    illegal,
    output logic                    err_timeout,
    output logic [INSTRET_W-1:0]    instret,
    output logic [2:0]              state
);

    state_t  state_q, state_d;
    iclass_t cls_q, dec_cls;
    logic    dec_legal;
    logic    retire;
    logic    timeout_hit;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    seq_class_decode u_decode (
        .opcode (bus.opcode),
        .iclass (dec_cls),
        .legal  (dec_legal)
    );

    always_comb begin
        state_d          = state_q;
        retire           = 1'b0;
        bus.imem_req     = 1'b0;
        bus.ir_write     = 1'b0;
        bus.pc_write     = 1'b0;
        bus.PC_src       = 1'b0;
        bus.alu_op       = '0;
        bus.alu_src      = 1'b0;
        bus.reg_write_en = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_to_reg   = 1'b0;

        // ALU controls follow the registered class for the whole EXEC..WB span.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)
            {bus.alu_op, bus.alu_src} = class_alu(cls_q);

        case (state_q)
            S_IDLE: if (start) state_d = S_FETCH;
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_write = 1'b1;
                    state_d      = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: state_d = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                case (cls_q)
                    CLS_L, CLS_S: state_d = S_MEM;
                    CLS_CB: begin
                        retire     = 1'b1;
                        bus.PC_src = bus.branch_cond;
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                bus.mem_read  = (cls_q == CLS_L);
                bus.mem_write = (cls_q == CLS_S);
                if (bus.dmem_ready) begin
                    if (cls_q == CLS_L) state_d = S_WB;
                    else                retire  = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                end
            end
            S_WB: begin
                bus.reg_write_en = 1'b1;
                bus.mem_to_reg   = (cls_q == CLS_L);
                retire           = 1'b1;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        if (retire) begin
            bus.pc_write = 1'b1;
            state_d      = halt ? S_IDLE : S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cls_q   <= CLS_NONE;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= dec_cls;
                if (!dec_legal) illegal <= 1'b1;
            end
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              waiting;

    // Counter is zero whenever no wait is in progress, so it is clear on entry to FETCH/MEM.
    assign waiting     = (state_q == S_FETCH && !bus.imem_ready) ||
                         (state_q == S_MEM   && !bus.dmem_ready);
    assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32I core.
- Steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
- Drives the same datapath control signals as the single-cycle decoder, plus PC/IR write enables and memory handshakes.
- Sits between the IR/opcode field, the instruction and data memories, and the ALU/regfile datapath.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter.
- TIMEOUT_CYCLES, 255, maximum consecutive wait cycles on a memory handshake. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching.
- halt  input  1  sampled in the retire cycle; 1 means return to IDLE.
- opcode  input  7  instruction[6:0] from the IR; valid from DECODE onward.
- branch_cond  input  1  datapath branch-compare result; valid in EXEC.
- imem_req  output  1  instruction fetch request.
- imem_ready  input  1  instruction word valid this cycle.
- dmem_ready  input  1  data access complete this cycle.
- ir_write  output  1  load the IR.
- pc_write  output  1  update the PC.
- PC_src  output  1  1 selects the branch target, 0 selects PC+4.
- alu_op  output  3  ALU operation class, using the defs.v ALU_OP_* encodings.
- alu_src  output  1  1 selects the immediate operand.
- reg_write_en  output  1  register-file write enable.
- mem_read  output  1  data-memory read request.
- mem_write  output  1  data-memory write request.
- mem_to_reg  output  1  1 selects memory data for write-back.
- illegal  output  1  sticky error flag.
- err_timeout  output  1  sticky timeout flag.
- instret  output  INSTRET_W  count of retired instructions.
- state  output  3  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, takes effect mid-instruction too):
  - State goes to IDLE; all outputs 0; instret 0; instruction class cleared.
  - imem_req and mem_read/mem_write drop immediately; any in-flight handshake is abandoned.
- State encodings (shared constants): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: all control outputs 0. start=1 → FETCH.
- FETCH: imem_req=1 and held until imem_ready. In the imem_ready cycle, ir_write=1 (combinational with imem_ready) and next state is DECODE.
- DECODE:
  - Classifies opcode into a registered class: R, I, L, S, CB, LUI or AUIPC.
  - Legal class → EXEC.
  - Any other opcode, including JAL and JALR (unsupported in this revision) → TRAP.
- EXEC:
  - alu_op and alu_src per class: R uses ALU_OP_R_type with alu_src 0; I uses ALU_OP_I_type with alu_src 1; L and S use ALU_OP_LW_SW_type with alu_src 1; CB uses ALU_OP_CB_type with alu_src 0; LUI and AUIPC use their own ALU_OP_* with alu_src 1.
  - alu_op and alu_src hold these values through MEM and WB for the same instruction.
  - Next state: R, I, LUI, AUIPC → WB. L, S → MEM.
  - CB retires in EXEC: pc_write=1, PC_src=branch_cond.
- MEM: mem_read=1 for L, mem_write=1 for S, held until dmem_ready.
  - L: dmem_ready → WB.
  - S: retires in the dmem_ready cycle.
- WB: reg_write_en=1 for one cycle; mem_to_reg=1 for L only; instruction retires.
- Retire cycle:
  - pc_write=1; PC_src=0 unless it is a taken CB.
  - instret increments, wrapping modulo 2^INSTRET_W.
  - Next state is IDLE if halt=1, otherwise FETCH.
- Latency with zero-wait memories: CB 3 cycles; R, I, LUI, AUIPC and S 4 cycles; L 5 cycles.
- TRAP: illegal=1 (or err_timeout=1); all control outputs 0. Exit only via rst; start is ignored.
- Handshake rules:
  - Request signals stay stable until their ready is seen.
  - ready while no request is outstanding is ignored.
  - start or halt outside their sampling points is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - When the counter reaches TIMEOUT_CYCLES with ready still low, next state is TRAP and err_timeout=1 (sticky).
  - ready arriving on the same cycle as the limit wins: no trap.
- Undefined: no counter, waits are unbounded, err_timeout tied to 0.

Decomposition:
- defs.v holds the opcode macros, ALU_OP_* encodings, the state encodings and the class encodings.
- One sub-module, seq_class_decode: combinational opcode → {class, legal}. The FSM plus counters stay in multicycle_sequencer.

Test Plan:
- Zero-wait R-type: rst, start=1, opcode=0110011, imem_ready and dmem_ready tied 1 → 4-cycle sequence FETCH→DECODE→EXEC→WB; reg_write_en pulses once; instret 0→1.
- Load with dmem_ready delayed 3 cycles: opcode=0000011 → mem_read held 4 cycles; then WB with mem_to_reg=1; total 8 cycles.
- Branch, opcode=1100011:
  - branch_cond=1 → PC_src=1, pc_write=1 in EXEC; retires in 3 cycles.
  - branch_cond=0 → PC_src=0.
- Illegal opcode 1101111 (JAL) → TRAP after DECODE; illegal=1; outputs 0; stays in TRAP under start=1 until rst.
- halt=1 in a store retire cycle → IDLE; rst asserted mid-MEM → mem_write drops the same cycle and instret=0.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ready held 0 → TRAP with err_timeout=1 after 4 FETCH cycles.
